// File: rtl/irq_pkg.sv
// Shared types and helper encoders for the 32-line interrupt/event priority encoder.
package irq_pkg;

  localparam int N     = 32;
  localparam int IDX_W = 5;

  typedef logic [31:0] req_vec_t;
  typedef logic [4:0]  idx_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic req_vec_t onehot(input idx_t i);
    return req_vec_t'(1) << i;
  endfunction

  // The winning bit is the one written last in the scan; the scan order sets the priority.
  function automatic logic [2:0] enc8(input logic [7:0] v, input bit low_first);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (low_first) begin
        if (v[7-i]) r = 3'(7 - i);
      end else if (v[i]) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v, input bit low_first);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (low_first) begin
        if (v[3-i]) r = 2'(3 - i);
      end else if (v[i]) begin
        r = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_encode32to5.sv
// Combinational 32-to-5 priority encoder: four 8-to-3 group encoders and a 4-to-2 group select.
module priority_encode32to5
  import irq_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic [31:0] vec,
  output logic [4:0]  idx,
  output logic        hit
);

  logic [3:0] grp_hit;
  logic [2:0] grp_idx [4];
  logic [1:0] grp_sel;

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      grp_hit[g] = |vec[g*8 +: 8];
      grp_idx[g] = enc8(vec[g*8 +: 8], LOW_FIRST);
    end
    grp_sel = enc4(grp_hit, LOW_FIRST);
    hit     = |grp_hit;
    // With no hit, group 0 is selected and its encoder yields 0, so idx is 0.
    idx     = {grp_sel, grp_idx[grp_sel]};
  end

endmodule

// File: rtl/irq_encode32to5.sv
// Sticky pending register, present/accept FSM and registered index output for 32 request lines.
//   state   | meaning
//   IDLE    | nothing presented; loads the best masked pending index when one exists
//   PRESENT | out_idx held and valid until accepted; back-to-back reload on accept
module irq_encode32to5
  import irq_pkg::*;
#(
  parameter int N         = 32,
  parameter int IDX_W     = 5,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic [N-1:0]     pending,
  output logic             any_pending
);

  state_t   state, state_next;
  req_vec_t ack_clr, pending_eff, pending_next;
  idx_t     sel;
  logic     hit, load;

  assign out_valid    = (state == PRESENT);
  assign ack_clr      = (out_valid && out_ready) ? onehot(out_idx) : '0;
  assign pending_eff  = pending & ~ack_clr;
  // A request re-asserted on the line being accepted survives the clear.
  assign pending_next = pending_eff | req_in;
  assign any_pending  = |(pending & mask);
  assign out_onehot   = out_valid ? onehot(out_idx) : '0;

  priority_encode32to5 #(.LOW_FIRST(LOW_FIRST)) u_penc (
    .vec (pending_eff & mask),
    .idx (sel),
    .hit (hit)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          load       = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (hit) load = 1'b1;
          else     state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      out_idx <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (load) out_idx <= sel;
    end
  end

endmodule

// File: tb/tb_irq_encode32to5.sv
// Directed bench for irq_encode32to5: expected accepted indices are queued, a monitor checks each handshake.
module tb_irq_encode32to5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_in, mask;
  logic        out_valid, out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_onehot, pending;
  logic        any_pending;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  irq_encode32to5 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_in      (req_in),
    .mask        (mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_onehot  (out_onehot),
    .pending     (pending),
    .any_pending (any_pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sampled mid-cycle: a valid&ready seen here is the handshake taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: got idx %0d, expected none at %0t", out_idx, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("hs_idx", 32'(out_idx), 32'(e));
        chk("hs_onehot", out_onehot, 32'(1) << e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_in = 32'hFFFF_FFFF; mask = 32'hFFFF_FFFF; out_ready = 1'b0;
    step(3);
    chk("rst_pending", pending, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_idx", 32'(out_idx), 32'h0);
    chk("rst_onehot", out_onehot, 32'h0);
    rst_n = 1'b1; req_in = 32'h0;
    step(2);
    chk("idle_pending", pending, 32'h0);
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_any", 32'(any_pending), 32'h0);

    // single request, held while not ready
    req_in = 32'h0000_0400;
    step(1); req_in = 32'h0;
    chk("single_pending", pending, 32'h400);
    chk("single_any", 32'(any_pending), 32'h1);
    chk("single_latency_valid", 32'(out_valid), 32'h0);
    step(1);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_idx", 32'(out_idx), 32'd10);
    chk("single_onehot", out_onehot, 32'h400);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("single_hold_valid", 32'(out_valid), 32'h1);
      chk("single_hold_idx", 32'(out_idx), 32'd10);
    end
    exp_q.push_back(10); out_ready = 1'b1;
    step(1); out_ready = 1'b0;
    chk("single_cleared", pending, 32'h0);
    chk("single_idle", 32'(out_valid), 32'h0);

    // priority order, back-to-back accepts
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(31);
    req_in = 32'h8000_0011; out_ready = 1'b1;
    step(1); req_in = 32'h0;
    step(1); chk("b2b_idx0", 32'(out_idx), 32'd0);  chk("b2b_v0", 32'(out_valid), 32'h1);
    step(1); chk("b2b_idx4", 32'(out_idx), 32'd4);  chk("b2b_v1", 32'(out_valid), 32'h1);
    step(1); chk("b2b_idx31", 32'(out_idx), 32'd31); chk("b2b_v2", 32'(out_valid), 32'h1);
    step(1); chk("b2b_done", 32'(out_valid), 32'h0); chk("b2b_pending", pending, 32'h0);
    out_ready = 1'b0;

    // presented index stays stable despite a higher-priority arrival
    req_in = 32'h20;
    step(1); req_in = 32'h0;
    step(1); chk("stab_idx", 32'(out_idx), 32'd5);
    req_in = 32'h1;
    step(1); req_in = 32'h0;
    chk("stab_idx_after_req", 32'(out_idx), 32'd5);
    chk("stab_pending", pending, 32'h21);
    step(2); chk("stab_idx_held", 32'(out_idx), 32'd5);
    exp_q.push_back(5); exp_q.push_back(0); out_ready = 1'b1;
    step(1); chk("stab_next_idx", 32'(out_idx), 32'd0); chk("stab_next_valid", 32'(out_valid), 32'h1);
    step(1); out_ready = 1'b0;
    chk("stab_idle", 32'(out_valid), 32'h0);

    // masking
    mask = 32'hFFFF_FFFE; req_in = 32'h3;
    step(1); req_in = 32'h0;
    step(1); chk("mask_idx", 32'(out_idx), 32'd1); chk("mask_any", 32'(any_pending), 32'h1);
    exp_q.push_back(1); out_ready = 1'b1;
    step(1); out_ready = 1'b0;
    chk("mask_idle", 32'(out_valid), 32'h0);
    chk("mask_pending", pending, 32'h1);
    chk("mask_any_off", 32'(any_pending), 32'h0);
    step(2); chk("mask_still_idle", 32'(out_valid), 32'h0);
    mask = 32'hFFFF_FFFF;
    step(1); chk("unmask_valid", 32'(out_valid), 32'h1); chk("unmask_idx", 32'(out_idx), 32'd0);
    exp_q.push_back(0); out_ready = 1'b1;
    step(1); out_ready = 1'b0;
    chk("unmask_cleared", pending, 32'h0);

    // mask removed while presenting: index still delivered
    req_in = 32'h100;
    step(1); req_in = 32'h0;
    step(1); chk("late_mask_idx", 32'(out_idx), 32'd8);
    mask = ~32'h100;
    step(2); chk("late_mask_valid", 32'(out_valid), 32'h1); chk("late_mask_held", 32'(out_idx), 32'd8);
    exp_q.push_back(8); out_ready = 1'b1;
    step(1); out_ready = 1'b0; mask = 32'hFFFF_FFFF;
    chk("late_mask_cleared", pending, 32'h0);
    chk("late_mask_idle", 32'(out_valid), 32'h0);

    // set wins over clear on the accepted line
    req_in = 32'h80;
    step(1); req_in = 32'h0;
    step(1); chk("sw_idx", 32'(out_idx), 32'd7);
    exp_q.push_back(7); exp_q.push_back(7);
    out_ready = 1'b1; req_in = 32'h80;
    step(1); out_ready = 1'b0; req_in = 32'h0;
    chk("sw_pending", pending, 32'h80);
    chk("sw_gap", 32'(out_valid), 32'h0);
    step(1); chk("sw_repr_valid", 32'(out_valid), 32'h1); chk("sw_repr_idx", 32'(out_idx), 32'd7);
    out_ready = 1'b1;
    step(1); out_ready = 1'b0;
    chk("sw_cleared", pending, 32'h0);

    // reset mid-presentation discards the in-flight index
    req_in = 32'h0000_1000;
    step(1); req_in = 32'h0;
    step(1); chk("mid_rst_pre", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_pending", pending, 32'h0);
    chk("mid_rst_idx", 32'(out_idx), 32'h0);
    step(1); rst_n = 1'b1;
    step(2);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
